// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC constants and the flit type.
// FLIT_W is the flit width. BUF_DEPTH is the input buffer depth and is also
// the upstream credit counter's reset value, so the two always match.
package noc_pkg;
    localparam int FLIT_W    = 32;
    localparam int BUF_DEPTH = 4;
    typedef logic [FLIT_W-1:0] flit_t;
endpackage

// File: rtl/ifc_flit_buffer.sv
// ifc_flit_buffer: bundle that mirrors the flit_buffer port list.
// Ports: clk, rst_n (active-low async reset).
// Modport dut is the buffer side and modport bench is the driver side.
// ovf_o is only present when FLIT_BUF_ERR_EN is defined.
interface ifc_flit_buffer #(
    parameter int FLIT_W = noc_pkg::FLIT_W
) (
    input logic clk,
    input logic rst_n
);
    logic [FLIT_W-1:0] flit_i;
    logic              valid_i;
    logic              rd_en_i;
    logic [FLIT_W-1:0] flit_o;
    logic              empty_o;
    logic              full_o;
    logic              credit_o;
`ifdef FLIT_BUF_ERR_EN
    logic              ovf_o;
`endif
    modport dut (
        input  clk, rst_n, flit_i, valid_i, rd_en_i,
`ifdef FLIT_BUF_ERR_EN
        output ovf_o,
`endif
        output flit_o, empty_o, full_o, credit_o
    );
    modport bench (
        input  clk, rst_n, flit_o, empty_o, full_o, credit_o,
`ifdef FLIT_BUF_ERR_EN
        input  ovf_o,
`endif
        output flit_i, valid_i, rd_en_i
    );
endinterface

// File: rtl/flit_buffer.sv
// flit_buffer: per-input-port show-ahead flit FIFO that returns one credit per pop.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   flit_i        incoming flit
//   valid_i       flit_i is valid this cycle
//   rd_en_i       the switch consumes the head flit
//   flit_o        head flit, valid while empty_o is 0
//   empty_o       no flits are stored
//   full_o        DEPTH flits are stored
//   credit_o      registered one-cycle credit pulse for each pop
//   ovf_o         sticky overflow flag, present only when FLIT_BUF_ERR_EN is defined
module flit_buffer #(
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int DEPTH  = noc_pkg::BUF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              valid_i,
    input  logic              rd_en_i,
    output logic [FLIT_W-1:0] flit_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              credit_o
`ifdef FLIT_BUF_ERR_EN
    ,
    output logic              ovf_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              credit_q, credit_d;
    logic              push, pop;

    assign empty_o  = count_q == '0;
    assign full_o   = count_q == CW'(DEPTH);
    assign flit_o   = mem_q[rd_ptr_q];
    assign credit_o = credit_q;

    // When the buffer is full, a push is accepted only if a pop frees the slot in the same cycle.
    always_comb begin
        pop      = rd_en_i && !empty_o;
        push     = valid_i && (!full_o || pop);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        credit_d = pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            credit_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            credit_q <= credit_d;
        end
    end

    // Storage has no reset: a pointer reset is enough to make stale data unreachable.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= flit_i;
    end

`ifdef FLIT_BUF_ERR_EN
    logic ovf_q, ovf_d;

    assign ovf_o = ovf_q;

    always_comb ovf_d = ovf_q || (valid_i && full_o && !pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
`endif
endmodule

// File: tb/tb_flit_buffer.sv
// tb_flit_buffer: scoreboard bench for flit_buffer with directed stimulus.
module tb_flit_buffer;
    localparam int DEPTH = noc_pkg::BUF_DEPTH;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    noc_pkg::flit_t flit_i = '0;
    logic           valid_i = 1'b0;
    logic           rd_en_i = 1'b0;
    noc_pkg::flit_t flit_o;
    logic           empty_o, full_o, credit_o;
`ifdef FLIT_BUF_ERR_EN
    logic           ovf_o;
`endif

    flit_buffer #(.FLIT_W(noc_pkg::FLIT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flit_i(flit_i), .valid_i(valid_i), .rd_en_i(rd_en_i),
        .flit_o(flit_o), .empty_o(empty_o), .full_o(full_o), .credit_o(credit_o)
`ifdef FLIT_BUF_ERR_EN
        , .ovf_o(ovf_o)
`endif
    );

    always #5 clk = ~clk;

    int             checks = 0;
    int             failures = 0;
    noc_pkg::flit_t sb[$];
    logic           exp_credit = 1'b0;
    logic           exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_empty"}, 32'(empty_o), 32'(sb.size() == 0));
        chk({tag, "_full"}, 32'(full_o), 32'(sb.size() == DEPTH));
        chk({tag, "_credit"}, 32'(credit_o), 32'(exp_credit));
`ifdef FLIT_BUF_ERR_EN
        chk({tag, "_ovf"}, 32'(ovf_o), 32'(exp_ovf));
`endif
    endtask

    // Called at a negedge. It checks the current outputs, drives one cycle of stimulus,
    // updates the model, and returns at the next negedge.
    task automatic cyc(input string tag, input logic v, input noc_pkg::flit_t f, input logic r);
        logic p, w;
        noc_pkg::flit_t e;
        chk_state(tag);
        p = r && sb.size() > 0;
        w = v && (sb.size() < DEPTH || p);
        if (p) begin
            e = sb.pop_front();
            chk({tag, "_head"}, flit_o, e);
        end
        if (w) sb.push_back(f);
        if (v && !w) exp_ovf = 1'b1;
        exp_credit = p;
        valid_i = v;
        flit_i = f;
        rd_en_i = r;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        rd_en_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = sb.size();
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, '0, 1'b1);
        cyc({tag, "_post"}, 1'b0, '0, 1'b0);
    endtask

    task automatic fill(input string tag, input noc_pkg::flit_t base);
        for (int i = 0; i < DEPTH; i++) cyc(tag, 1'b1, base + noc_pkg::flit_t'(i), 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_state("reset");
        rst_n = 1'b1;
        cyc("push1", 1'b1, 32'hA5A5_0001, 1'b0);
        chk("first_head", flit_o, 32'hA5A5_0001);
        drain("pop1");
        fill("fill_a", 32'h1);
        drain("drain_a");
        fill("fill_b", 32'h1);
        cyc("full_pp", 1'b1, 32'h5, 1'b1);
        drain("drain_b");
        cyc("empty_pp", 1'b1, 32'h77, 1'b1);
        cyc("empty_pp_after", 1'b0, '0, 1'b0);
        drain("drain_c");
        fill("fill_d", 32'h11);
        cyc("ovf_push", 1'b1, 32'hDEAD_BEEF, 1'b0);
        cyc("ovf_hold", 1'b0, '0, 1'b0);
        drain("drain_d");
        fill("fill_e", 32'h21);
        cyc("pre_rst_pop", 1'b0, '0, 1'b1);
        chk_state("pre_rst");
        rst_n = 1'b0;
        #1;
        sb.delete();
        exp_credit = 1'b0;
        exp_ovf = 1'b0;
        chk_state("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_rst", 1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) cyc("wrap", 1'b1, noc_pkg::flit_t'($urandom), 1'b1);
        fill("wrap_fill", 32'h31);
        drain("wrap_drain");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
